// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter and next-PC selection for the instruction fetch stage.
// Redirects seen during a stall are buffered; a halt word stops fetch until reset.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic [31:0]      imem_data,
    output logic [31:0]      imem_addr,
    output logic [31:0]      pc,
    output logic [31:0]      pc_added,
    output logic [31:0]      instruction,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);
    typedef enum logic {RUN, HALT} state_t;

    state_t             state_q;
    logic [31:0]        pc_q, pc_d, pend_target_q, live_target;
    logic               pend_valid_q, live, run, redirect, halt_hit;
    logic [CNT_W-1:0]   cnt_q;

    always_comb begin
        live        = branch_taken | jump;
        live_target = branch_taken ? {branch_target[31:2], 2'b00} : {jump_target[31:2], 2'b00};
        run         = state_q == RUN;
        redirect    = live | pend_valid_q;
        halt_hit    = run & ~stall & (imem_data == HALT_WORD) & ~redirect;
        pc_d        = live ? live_target : pend_valid_q ? pend_target_q : pc_q + 32'd4;
        flush       = run & ~stall & redirect;
        halted      = ~run;
        pc          = pc_q;
        imem_addr   = pc_q;
        pc_added    = pc_q + 32'd4;
        instruction = run ? imem_data : 32'h0;
        fetch_count = cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
            cnt_q         <= '0;
        end else if (run) begin
            if (stall) begin
                // newest redirect during a stall replaces any older one
                if (live) begin
                    pend_valid_q  <= 1'b1;
                    pend_target_q <= live_target;
                end
            end else if (halt_hit) begin
                state_q <= HALT;
            end else begin
                pc_q         <= pc_d;
                pend_valid_q <= 1'b0;
                if (cnt_q != '1)
                    cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed vectors against three parameterisations of fetch_pc_unit.
module tb_fetch_pc_unit;
    logic        clk = 1'b0;
    logic        rst, stall, branch_taken, jump;
    logic [31:0] branch_target, jump_target, imem_data;
    logic [31:0] a_addr, a_pc, a_pa, a_ins, w_addr, w_pc, w_pa, w_ins, s_addr, s_pc, s_pa, s_ins;
    logic        a_fl, a_h, w_fl, w_h, s_fl, s_h;
    logic [15:0] a_cnt, w_cnt;
    logic [3:0]  s_cnt;
    int          vectors = 0, errors = 0;

    always #5 clk = ~clk;

    fetch_pc_unit u_dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .imem_data(imem_data), .imem_addr(a_addr), .pc(a_pc),
        .pc_added(a_pa), .instruction(a_ins), .flush(a_fl), .halted(a_h), .fetch_count(a_cnt));

    fetch_pc_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .imem_data(imem_data), .imem_addr(w_addr), .pc(w_pc),
        .pc_added(w_pa), .instruction(w_ins), .flush(w_fl), .halted(w_h), .fetch_count(w_cnt));

    fetch_pc_unit #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .imem_data(imem_data), .imem_addr(s_addr), .pc(s_pc),
        .pc_added(s_pa), .instruction(s_ins), .flush(s_fl), .halted(s_h), .fetch_count(s_cnt));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        stall = 0; branch_taken = 0; jump = 0;
        branch_target = 0; jump_target = 0; imem_data = 0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    initial begin
        clear_in();
        rst = 1;
        imem_data = 32'h1234_5678;
        tick(2);
        chk("rst_pc", a_pc, 32'h0);
        chk("rst_addr", a_addr, 32'h0);
        chk("rst_pc_added", a_pa, 32'h4);
        chk("rst_instr", a_ins, 32'h1234_5678);
        chk("rst_flush", a_fl, 0);
        chk("rst_halted", a_h, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("wrap_rst_pc_added", w_pa, 32'hFFFF_FFFC);
        rst = 0;
        imem_data = 0;
        #1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("seq_pc", a_pc, 32'(4 * i));
            chk("seq_pc_added", a_pa, 32'(4 * i + 4));
            chk("seq_flush", a_fl, 0);
            if (i == 1) begin
                chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
                chk("wrap_pc_added", w_pa, 32'h0);
            end
            if (i == 2) chk("wrap_pc2", w_pc, 32'h0);
        end
        chk("seq_cnt", a_cnt, 4);

        // branch and jump together at pc=8: branch wins
        do_reset();
        tick(2);
        chk("br_pre_pc", a_pc, 32'h8);
        branch_taken = 1; branch_target = 32'h40; jump = 1; jump_target = 32'h80;
        #1;
        chk("br_flush", a_fl, 1);
        tick();
        clear_in();
        #1;
        chk("br_pc", a_pc, 32'h40);
        chk("br_cnt", a_cnt, 3);
        chk("br_flush_after", a_fl, 0);

        // jump latched during a 3-cycle stall at pc=12
        do_reset();
        tick(3);
        stall = 1;
        tick();
        jump = 1; jump_target = 32'h103;
        #1;
        chk("stall_flush", a_fl, 0);
        tick();
        jump = 0;
        tick();
        chk("stall_pc", a_pc, 32'hC);
        chk("stall_cnt", a_cnt, 3);
        stall = 0;
        #1;
        chk("rel_flush", a_fl, 1);
        tick();
        chk("rel_pc", a_pc, 32'h100);
        chk("rel_cnt", a_cnt, 4);
        chk("rel_flush_after", a_fl, 0);
        tick();
        chk("rel_seq_pc", a_pc, 32'h104);

        // newer redirect overwrites pending; live redirect on release wins
        do_reset();
        stall = 1; jump = 1; jump_target = 32'h200;
        tick();
        jump = 0; branch_taken = 1; branch_target = 32'h300;
        tick();
        branch_taken = 0;
        tick();
        stall = 0;
        tick();
        chk("overwrite_pc", a_pc, 32'h300);
        stall = 1; jump = 1; jump_target = 32'h500;
        tick();
        stall = 0; jump = 0; branch_taken = 1; branch_target = 32'h600;
        tick();
        branch_taken = 0;
        chk("live_beats_pend", a_pc, 32'h600);
        tick();
        chk("pend_cleared", a_pc, 32'h604);

        // halt at pc=0x20, then inputs ignored until reset
        do_reset();
        tick(8);
        chk("halt_pre_pc", a_pc, 32'h20);
        imem_data = 32'hFFFF_FFFF;
        #1;
        chk("halt_pre_flush", a_fl, 0);
        tick();
        chk("halt_h", a_h, 1);
        chk("halt_pc", a_pc, 32'h20);
        chk("halt_instr", a_ins, 32'h0);
        chk("halt_cnt", a_cnt, 8);
        branch_taken = 1; branch_target = 32'h40; imem_data = 0;
        #1;
        chk("halt_flush", a_fl, 0);
        tick();
        stall = 1; jump = 1; jump_target = 32'h80;
        tick();
        stall = 0;
        tick();
        chk("halt_hold_pc", a_pc, 32'h20);
        chk("halt_hold_h", a_h, 1);
        rst = 1;
        #1;
        chk("halt_rst_pc", a_pc, 32'h0);
        chk("halt_rst_h", a_h, 0);
        tick();
        rst = 0;
        clear_in();

        // halt word with a redirect is wrong-path
        do_reset();
        imem_data = 32'hFFFF_FFFF; branch_taken = 1; branch_target = 32'h10;
        #1;
        chk("wp_flush", a_fl, 1);
        tick();
        clear_in();
        #1;
        chk("wp_h", a_h, 0);
        chk("wp_pc", a_pc, 32'h10);

        // halt word during stall ignored; pending redirect suppresses halt on release
        do_reset();
        stall = 1; imem_data = 32'hFFFF_FFFF;
        tick();
        chk("stall_halt_h", a_h, 0);
        jump = 1; jump_target = 32'h44;
        tick();
        jump = 0; stall = 0;
        tick();
        chk("pend_halt_h", a_h, 0);
        chk("pend_halt_pc", a_pc, 32'h44);

        // reset mid-pending discards the redirect
        do_reset();
        stall = 1; jump = 1; jump_target = 32'h700;
        tick();
        rst = 1;
        #1;
        rst = 0; clear_in();
        tick();
        chk("rst_pend_pc", a_pc, 32'h4);

        // counter saturation
        do_reset();
        tick(20);
        chk("sat_cnt4", s_cnt, 4'hF);
        chk("sat_cnt16", a_cnt, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
